sender_nch: RTL and testbench

Parametrised, clocked multi-channel handshake sender for the base control layer. Each channel turns one-cycle `i_drive` pulses into request tokens on `outR`, in two-phase (toggle) or four-phase (return-to-zero) signalling, and tracks the receiver's `i_ack`. Drives that arrive while a handshake is outstanding are buffered in a per-channel pending counter. A common `i_free` token is forwarded to `o_free` through a programmable cycle delay.

---
 rtl/sender_nch.sv | 116 +++++++++++
 tb/tb_sender_nch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sender_nch.sv
// Multi-channel handshake sender: per-channel two- or four-phase request FSM with a
// pending-drive counter, plus a delayed forward of the shared free token.

module sender_ch #(
    parameter int DEPTH      = 3,
    parameter int FOUR_PHASE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       drive,
    input  logic                       ack,
    output logic                       outr,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] pend,
    output logic                       ovf
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, REQ, RTZ} state_t;

    state_t        st, nxt_st;
    logic          nxt_outr, nxt_ovf;
    logic [CW-1:0] nxt_pend;
    logic          can_launch, launch;

    always_comb begin
        can_launch = (st == IDLE) || (st == WAIT && ack == outr) || (st == RTZ && !ack);
        launch     = can_launch && (pend != '0 || drive);
        nxt_st     = st;
        nxt_outr   = outr;
        nxt_pend   = pend;
        nxt_ovf    = ovf;

        if (launch) begin
            nxt_outr = (FOUR_PHASE != 0) ? 1'b1 : ~outr;
            nxt_st   = (FOUR_PHASE != 0) ? REQ : WAIT;
        end else if (can_launch) begin
            nxt_st = IDLE;
        end else if (st == REQ && ack) begin
            nxt_outr = 1'b0;
            nxt_st   = RTZ;
        end

        // A drive arriving alongside a pending launch replaces the consumed token.
        if (launch && pend != '0 && !drive)
            nxt_pend = pend - 1'b1;
        else if (!launch && drive) begin
            if (pend < DEPTH_C) nxt_pend = pend + 1'b1;
            else                nxt_ovf  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            outr <= 1'b0;
            pend <= '0;
            ovf  <= 1'b0;
            busy <= 1'b0;
        end else begin
            st   <= nxt_st;
            outr <= nxt_outr;
            pend <= nxt_pend;
            ovf  <= nxt_ovf;
            busy <= (nxt_st != IDLE) || (nxt_pend != '0);
        end
    end
endmodule

module sender_nch #(
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 3,
    parameter int FREE_DELAY = 2,
    parameter int FOUR_PHASE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CHANNELS-1:0]                   i_drive,
    input  logic [CHANNELS-1:0]                   i_ack,
    input  logic                                  i_free,
    output logic [CHANNELS-1:0]                   outR,
    output logic                                  o_free,
    output logic [CHANNELS-1:0]                   o_busy,
    output logic [CHANNELS*$clog2(DEPTH+1)-1:0]   o_pending,
    output logic [CHANNELS-1:0]                   o_overflow
);
    localparam int CW = $clog2(DEPTH+1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        sender_ch #(
            .DEPTH      (DEPTH),
            .FOUR_PHASE (FOUR_PHASE)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .drive (i_drive[c]),
            .ack   (i_ack[c]),
            .outr  (outR[c]),
            .busy  (o_busy[c]),
            .pend  (o_pending[c*CW +: CW]),
            .ovf   (o_overflow[c])
        );
    end

    if (FREE_DELAY == 0) begin : g_free_comb
        assign o_free = i_free;
    end else begin : g_free_sr
        logic [FREE_DELAY-1:0] sr;
        always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= (sr << 1) | FREE_DELAY'(i_free);
        end
        assign o_free = sr[FREE_DELAY-1];
    end
endmodule

// File: tb/tb_sender_nch.sv
// Bench for sender_nch: two-phase/FREE_DELAY=3 and four-phase/FREE_DELAY=0 instances,
// vector table for channel sequences, queue scoreboard for the free-token delay line.

module tb_sender_nch;
    localparam int CH = 4;
    localparam int DEPTH = 3;
    localparam int CW = $clog2(DEPTH+1);
    localparam int FD = 3;

    logic clk = 1'b0;
    logic rst;
    logic free;
    logic [CH-1:0] drv2, ack2, drv4, ack4;
    logic [CH-1:0] outr2, busy2, ovf2, outr4, busy4, ovf4;
    logic [CH*CW-1:0] pend2, pend4;
    logic ofree2, ofree4;

    int errs = 0;
    int checks = 0;
    int q_free[$];

    always #5 clk = ~clk;

    sender_nch #(.CHANNELS(CH), .DEPTH(DEPTH), .FREE_DELAY(FD), .FOUR_PHASE(0)) u2 (
        .clk(clk), .rst(rst), .i_drive(drv2), .i_ack(ack2), .i_free(free),
        .outR(outr2), .o_free(ofree2), .o_busy(busy2), .o_pending(pend2), .o_overflow(ovf2));

    sender_nch #(.CHANNELS(CH), .DEPTH(DEPTH), .FREE_DELAY(0), .FOUR_PHASE(1)) u4 (
        .clk(clk), .rst(rst), .i_drive(drv4), .i_ack(ack4), .i_free(free),
        .outR(outr4), .o_free(ofree4), .o_busy(busy4), .o_pending(pend4), .o_overflow(ovf4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every edge pushes the sampled free bit; the delayed output must reproduce it FD edges later.
    task automatic tick();
        int e;
        @(posedge clk);
        if (rst) q_free.delete();
        else     q_free.push_back(int'(free));
        #1;
        if (q_free.size() >= FD) begin
            e = q_free.pop_front();
            chk("o_free_d3", 32'(ofree2), 32'(e));
        end else
            chk("o_free_d3_startup", 32'(ofree2), 0);
        chk("o_free_d0", 32'(ofree4), 32'(free));
    endtask

    typedef struct {
        bit   fp;
        logic d, a, outr;
        int   pend;
        logic busy, ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit fp, logic d, logic a, logic o, int p, logic b, logic v);
        vec_t r;
        r.fp = fp; r.d = d; r.a = a; r.outr = o; r.pend = p; r.busy = b; r.ovf = v;
        tbl.push_back(r);
    endfunction

    initial begin
        // two-phase, channel 1: fill pending, overflow, drain via ack toggles
        add(0, 1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 1, 0);
        add(0, 1, 0, 1, 2, 1, 0);
        add(0, 1, 0, 1, 3, 1, 0);
        add(0, 1, 0, 1, 3, 1, 1);
        add(0, 0, 0, 1, 3, 1, 1);
        add(0, 0, 1, 0, 2, 1, 1);
        add(0, 0, 1, 0, 2, 1, 1);
        add(0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        // simultaneous ack completion and drive with pending=2
        add(0, 1, 0, 1, 0, 1, 1);
        add(0, 1, 0, 1, 1, 1, 1);
        add(0, 1, 0, 1, 2, 1, 1);
        add(0, 1, 1, 0, 2, 1, 1);
        add(0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        // four-phase, channel 0: two tokens, relaunch on the RTZ-complete edge
        add(1, 1, 0, 1, 0, 1, 0);
        add(1, 1, 0, 1, 1, 1, 0);
        add(1, 0, 1, 0, 1, 1, 0);
        add(1, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; free = 1'b0;
        drv2 = '1; drv4 = '1; ack2 = '0; ack4 = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_outr2", 32'(outr2), 0);
            chk("rst_pend2", 32'(pend2), 0);
            chk("rst_ovf2",  32'(ovf2), 0);
            chk("rst_busy2", 32'(busy2), 0);
            chk("rst_outr4", 32'(outr4), 0);
            chk("rst_busy4", 32'(busy4), 0);
        end
        rst = 1'b0; drv2 = '0; drv4 = '0;
        tick();
        tick();

        // two-phase single token on channel 0
        drv2[0] = 1'b1;
        tick();
        drv2[0] = 1'b0;
        chk("single_outr", 32'(outr2[0]), 1);
        chk("single_busy", 32'(busy2[0]), 1);
        tick();
        chk("single_hold_busy", 32'(busy2[0]), 1);
        ack2[0] = 1'b1;
        tick();
        chk("single_done_busy", 32'(busy2[0]), 0);
        chk("single_done_outr", 32'(outr2[0]), 1);

        foreach (tbl[i]) begin
            if (!tbl[i].fp) begin drv2[1] = tbl[i].d; ack2[1] = tbl[i].a; end
            else            begin drv4[0] = tbl[i].d; ack4[0] = tbl[i].a; end
            tick();
            if (!tbl[i].fp) begin
                chk($sformatf("row%0d_outr", i), 32'(outr2[1]), 32'(tbl[i].outr));
                chk($sformatf("row%0d_pend", i), 32'(pend2[1*CW +: CW]), 32'(tbl[i].pend));
                chk($sformatf("row%0d_busy", i), 32'(busy2[1]), 32'(tbl[i].busy));
                chk($sformatf("row%0d_ovf", i),  32'(ovf2[1]), 32'(tbl[i].ovf));
            end else begin
                chk($sformatf("row%0d_outr", i), 32'(outr4[0]), 32'(tbl[i].outr));
                chk($sformatf("row%0d_pend", i), 32'(pend4[0 +: CW]), 32'(tbl[i].pend));
                chk($sformatf("row%0d_busy", i), 32'(busy4[0]), 32'(tbl[i].busy));
                chk($sformatf("row%0d_ovf", i),  32'(ovf4[0]), 32'(tbl[i].ovf));
            end
        end
        drv2 = '0; drv4 = '0;

        // free pulses at cycles 10, 11, 14 of this window, including back-to-back
        for (int k = 0; k < 20; k++) begin
            free = (k == 10 || k == 11 || k == 14);
            tick();
        end
        free = 1'b0;
        tick();

        // reset mid-handshake abandons tokens and clears the sticky overflow
        drv2[2] = 1'b1;
        tick();
        drv2[2] = 1'b0;
        chk("pre_rst_outr", 32'(outr2[2]), 1);
        rst = 1'b1; drv2 = '1;
        tick();
        chk("mid_rst_outr", 32'(outr2), 0);
        chk("mid_rst_pend", 32'(pend2), 0);
        chk("mid_rst_ovf",  32'(ovf2), 0);
        chk("mid_rst_busy", 32'(busy2), 0);
        rst = 1'b0; drv2 = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
